// File: rtl/locker_keypad_frontend.sv
// rtl/locker_keypad_frontend.sv - user-side command initiator for the takeaway locker controller
// Collects deposit/pickup, box and a serial 4-bit key, drives the locker request lines,
// decodes the locker status LEDs into a result code and acknowledges error states.
// Optional feature macro: KEYPAD_LOCKOUT_EN (lockout after MAX_RETRY consecutive key errors).
module locker_keypad_frontend #(
  parameter int ENTRY_TIMEOUT  = 200,
  parameter int RESP_TIMEOUT   = 16
`ifdef KEYPAD_LOCKOUT_EN
  ,
  parameter int MAX_RETRY      = 3,
  parameter int LOCKOUT_CYCLES = 1000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_push_i,
  input  logic       cmd_pop_i,
  input  logic       cmd_ok_i,
  input  logic       cmd_clear_i,
  input  logic [1:0] box_sel_i,
  input  logic       key_bit_i,
  input  logic       key_bit_vld_i,
  input  logic       waitled_i,
  input  logic       overloadled_i,
  input  logic       nofoodled_i,
  input  logic       keyerrorled_i,
  input  logic       pushled_i,
  input  logic       popled_i,
  output logic [1:0] func_o,
  output logic [1:0] whichbox_o,
  output logic [3:0] key_o,
  output logic       getinfo_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] result_o
);

  localparam logic [2:0] RES_PUSH_OK  = 3'd1;
  localparam logic [2:0] RES_POP_OK   = 3'd2;
  localparam logic [2:0] RES_OVERLOAD = 3'd3;
  localparam logic [2:0] RES_NOFOOD   = 3'd4;
  localparam logic [2:0] RES_KEYERR   = 3'd5;
  localparam logic [2:0] RES_TIMEOUT  = 3'd6;

  // One shared timer serves entry idle, response and lockout timing.
  localparam int TMAX0 = (ENTRY_TIMEOUT > RESP_TIMEOUT) ? ENTRY_TIMEOUT : RESP_TIMEOUT;
`ifdef KEYPAD_LOCKOUT_EN
  localparam int TMAX  = (TMAX0 > LOCKOUT_CYCLES) ? TMAX0 : LOCKOUT_CYCLES;
  localparam int EW0   = $clog2(MAX_RETRY + 1);
  localparam int EW    = (EW0 < 2) ? 2 : EW0;
  localparam logic [2:0] RES_LOCKED = 3'd7;
`else
  localparam int TMAX  = TMAX0;
`endif
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [TW-1:0] RESP_LAST  = TW'(RESP_TIMEOUT - 1);
`ifdef KEYPAD_LOCKOUT_EN
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_ISSUE,
    S_WAITRESP,
    S_RETURN
`ifdef KEYPAD_LOCKOUT_EN
    ,
    S_LOCKOUT
`endif
  } state_t;

  state_t         state_q;
  logic [1:0]     op_q;
  logic [1:0]     func_q;
  logic [1:0]     whichbox_q;
  logic [3:0]     key_q;
  logic [2:0]     bitcnt_q;
  logic [TW-1:0]  tmr_q;
  logic [2:0]     res_q;
  logic           getinfo_q;
  logic           busy_q;
  logic           done_q;
  logic [2:0]     result_q;
`ifdef KEYPAD_LOCKOUT_EN
  logic [EW-1:0]  errcnt_q;
`endif
  logic [2:0]     resp_code;

  // Prioritised decode of the locker status LEDs; zero means nothing recognised yet.
  always_comb begin
    resp_code = 3'd0;
    if (overloadled_i)                 resp_code = RES_OVERLOAD;
    else if (nofoodled_i)              resp_code = RES_NOFOOD;
    else if (popled_i && keyerrorled_i) resp_code = RES_KEYERR;
    else if (pushled_i)                resp_code = RES_PUSH_OK;
    else if (popled_i)                 resp_code = RES_POP_OK;
  end

  // Command sequencing FSM with registered outputs; done/getinfo default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      func_q     <= 2'b00;
      whichbox_q <= 2'b00;
      key_q      <= 4'h0;
      bitcnt_q   <= 3'd0;
      tmr_q      <= '0;
      res_q      <= 3'd0;
      getinfo_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 3'd0;
`ifdef KEYPAD_LOCKOUT_EN
      errcnt_q   <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      getinfo_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_push_i || cmd_pop_i) begin
            op_q       <= cmd_push_i ? 2'b01 : 2'b10;
            whichbox_q <= box_sel_i;
            key_q      <= 4'h0;
            bitcnt_q   <= 3'd0;
            tmr_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (cmd_clear_i) begin
            key_q   <= 4'h0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cmd_ok_i && (bitcnt_q == 3'd4)) begin
            func_q  <= op_q;
            tmr_q   <= '0;
            state_q <= S_ISSUE;
          end else if (key_bit_vld_i) begin
            if (bitcnt_q != 3'd4) begin
              key_q    <= {key_q[2:0], key_bit_i};
              bitcnt_q <= bitcnt_q + 3'd1;
            end
            tmr_q <= '0;
          end else if (tmr_q == ENTRY_LAST) begin
            key_q   <= 4'h0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_ISSUE: begin
          if (!waitled_i) begin
            func_q  <= 2'b00;
            tmr_q   <= '0;
            state_q <= S_WAITRESP;
          end else if (tmr_q == RESP_LAST) begin
            done_q   <= 1'b1;
            result_q <= RES_TIMEOUT;
            func_q   <= 2'b00;
            key_q    <= 4'h0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_WAITRESP: begin
          if (resp_code != 3'd0) begin
            res_q     <= resp_code;
            getinfo_q <= (resp_code == RES_OVERLOAD) || (resp_code == RES_NOFOOD) ||
                         (resp_code == RES_KEYERR);
            tmr_q     <= '0;
            state_q   <= S_RETURN;
`ifdef KEYPAD_LOCKOUT_EN
            if ((resp_code == RES_KEYERR) && (errcnt_q != EW'(MAX_RETRY)))
              errcnt_q <= errcnt_q + 1'b1;
            else if (resp_code == RES_POP_OK)
              errcnt_q <= '0;
`endif
          end else if (tmr_q == RESP_LAST) begin
            done_q   <= 1'b1;
            result_q <= RES_TIMEOUT;
            key_q    <= 4'h0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_RETURN: begin
          if (waitled_i) begin
            done_q   <= 1'b1;
            result_q <= res_q;
            key_q    <= 4'h0;
            func_q   <= 2'b00;
            tmr_q    <= '0;
`ifdef KEYPAD_LOCKOUT_EN
            if (errcnt_q == EW'(MAX_RETRY)) begin
              state_q <= S_LOCKOUT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end else if (tmr_q == RESP_LAST) begin
            done_q   <= 1'b1;
            result_q <= RES_TIMEOUT;
            key_q    <= 4'h0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
`ifdef KEYPAD_LOCKOUT_EN
        S_LOCKOUT: begin
          if (cmd_push_i || cmd_pop_i) begin
            done_q   <= 1'b1;
            result_q <= RES_LOCKED;
          end
          if (tmr_q == LOCK_LAST) begin
            errcnt_q <= '0;
            tmr_q    <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign func_o     = func_q;
  assign whichbox_o = whichbox_q;
  assign key_o      = key_q;
  assign getinfo_o  = getinfo_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;

endmodule
